regfile_sb: RTL and testbench

Parametrised successor to the core register file.
- Generalised in width (XLEN), depth (NREGS: 32 for RV32I, 16 for RV32E) and number of read ports.
- Optional same-cycle write-to-read bypass.
- Per-register scoreboard (busy bits) for pipeline hazard detection.
- Sequenced scrub FSM that zeroes the array one entry per cycle after reset or on request.

Sits between decode (read/issue) and writeback in the pipelined core.

---
 rtl/regfile_sb_pkg.sv | 16 +
 rtl/regfile_sb_if.sv | 30 +++
 rtl/regfile_scoreboard.sv | 45 ++++
 rtl/regfile_sb.sv | 116 +++++++++++
 tb/tb_regfile_sb.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/regfile_sb_pkg.sv
// Shared RV32 register-file constants and index helpers.
package regfile_sb_pkg;

  localparam int unsigned XLEN_DEF    = 32;
  localparam int unsigned REG_IDX_W   = 5;
  localparam int unsigned NREGS_RV32I = 32;
  localparam int unsigned NREGS_RV32E = 16;
  localparam logic [REG_IDX_W-1:0] X0_IDX = '0;

  // An index addresses real storage only if it is not x0 and below the register count.
  function automatic logic idx_valid(input logic [REG_IDX_W-1:0] idx,
                                     input int unsigned nregs);
    return (idx != X0_IDX) && (32'(idx) < nregs);
  endfunction

endpackage

// File: rtl/regfile_sb_if.sv
// Decode/writeback-side bus of the register file; slave is the register file itself.
interface regfile_sb_if
  import regfile_sb_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NRD  = 2
);

  logic                       clear_i;
  logic                       ready_o;
  logic                       wen_i;
  logic [REG_IDX_W-1:0]       rd_idx_i;
  logic [XLEN-1:0]            rd_data_i;
  logic [NRD*REG_IDX_W-1:0]   rs_idx_i;
  logic [NRD*XLEN-1:0]        rs_data_o;
  logic [NRD-1:0]             rs_busy_o;
  logic                       iss_valid_i;
  logic [REG_IDX_W-1:0]       iss_idx_i;

  modport master (
    output clear_i, wen_i, rd_idx_i, rd_data_i, rs_idx_i, iss_valid_i, iss_idx_i,
    input  ready_o, rs_data_o, rs_busy_o
  );

  modport slave (
    input  clear_i, wen_i, rd_idx_i, rd_data_i, rs_idx_i, iss_valid_i, iss_idx_i,
    output ready_o, rs_data_o, rs_busy_o
  );

endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits: issue sets, writeback clears, set wins on collision.
module regfile_scoreboard
  import regfile_sb_pkg::*;
#(
  parameter  int unsigned NREGS = 32,
  parameter  int unsigned NRD   = 2,
  localparam int unsigned AW    = $clog2(NREGS)
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              clr_all_i,
  input  logic              set_i,
  input  logic [AW-1:0]     set_idx_i,
  input  logic              clr_i,
  input  logic [AW-1:0]     clr_idx_i,
  input  logic [NRD*AW-1:0] look_idx_i,
  output logic [NRD-1:0]    busy_o
);

  logic [NREGS-1:0] busy_q, busy_d;

  always_comb begin
    busy_d = busy_q;
    if (clr_all_i) begin
      busy_d = '0;
    end else begin
      if (clr_i) busy_d[clr_idx_i] = 1'b0;
      if (set_i) busy_d[set_idx_i] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) busy_q <= '0;
    else         busy_q <= busy_d;
  end

  always_comb begin
    busy_o = '0;
    for (int unsigned k = 0; k < NRD; k++) begin
      busy_o[k] = busy_q[look_idx_i[k*AW +: AW]];
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// Parametrised register file with optional write bypass, issue scoreboard and scrub sequencer.
module regfile_sb
  import regfile_sb_pkg::*;
#(
  parameter int unsigned XLEN   = XLEN_DEF,
  parameter int unsigned NREGS  = NREGS_RV32I,
  parameter int unsigned NRD    = 2,
  parameter bit          BYPASS = 1'b1
) (
  input logic         clk_i,
  input logic         reset_i,
  regfile_sb_if.slave rf
);

  localparam int unsigned   AW   = $clog2(NREGS);
  localparam logic [AW-1:0] LAST = AW'(NREGS - 1);

  typedef enum logic {ST_SCRUB, ST_READY} state_e;

  state_e            state_q, state_d;
  logic [AW-1:0]     cnt_q, cnt_d;
  logic [XLEN-1:0]   mem_q [NREGS];

  logic              ready;
  logic              wr_ok;
  logic              iss_ok;
  logic              clr_all;
  logic [NRD*AW-1:0] look_idx;
  logic [NRD-1:0]    sb_busy;
  logic [NRD*XLEN-1:0] rs_data;
  logic [NRD-1:0]      rs_busy;

  assign ready   = (state_q == ST_READY);
  assign wr_ok   = ready && rf.wen_i       && idx_valid(rf.rd_idx_i, NREGS);
  assign iss_ok  = ready && rf.iss_valid_i && idx_valid(rf.iss_idx_i, NREGS);
  assign clr_all = ready && rf.clear_i;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_SCRUB: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) state_d = ST_READY;
      end
      ST_READY: begin
        if (rf.clear_i) begin
          state_d = ST_SCRUB;
          cnt_d   = '0;
        end
      end
      default: state_d = ST_SCRUB;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ST_SCRUB;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Storage has no reset; the scrub sequence is what defines its contents.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      if (!ready)     mem_q[cnt_q]               <= '0;
      else if (wr_ok) mem_q[rf.rd_idx_i[AW-1:0]] <= rf.rd_data_i;
    end
  end

  always_comb begin
    look_idx = '0;
    for (int unsigned k = 0; k < NRD; k++) begin
      look_idx[k*AW +: AW] = rf.rs_idx_i[k*REG_IDX_W +: AW];
    end
  end

  regfile_scoreboard #(
    .NREGS(NREGS),
    .NRD  (NRD)
  ) u_sb (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .clr_all_i (clr_all),
    .set_i     (iss_ok),
    .set_idx_i (rf.iss_idx_i[AW-1:0]),
    .clr_i     (wr_ok),
    .clr_idx_i (rf.rd_idx_i[AW-1:0]),
    .look_idx_i(look_idx),
    .busy_o    (sb_busy)
  );

  // A forwarded value is by definition no longer pending, so bypass reports not-busy.
  always_comb begin
    rs_data = '0;
    rs_busy = '0;
    for (int unsigned k = 0; k < NRD; k++) begin
      if (ready && idx_valid(rf.rs_idx_i[k*REG_IDX_W +: REG_IDX_W], NREGS)) begin
        if (BYPASS && wr_ok && (rf.rd_idx_i == rf.rs_idx_i[k*REG_IDX_W +: REG_IDX_W])) begin
          rs_data[k*XLEN +: XLEN] = rf.rd_data_i;
        end else begin
          rs_data[k*XLEN +: XLEN] = mem_q[rf.rs_idx_i[k*REG_IDX_W +: AW]];
          rs_busy[k]              = sb_busy[k];
        end
      end
    end
  end

  assign rf.ready_o   = ready;
  assign rf.rs_data_o = rs_data;
  assign rf.rs_busy_o = rs_busy;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench: RV32I/bypass instance alongside an RV32E/no-bypass instance on identical stimulus.
module tb_regfile_sb;
  import regfile_sb_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  regfile_sb_if #(.XLEN(32), .NRD(2)) b32 ();
  regfile_sb_if #(.XLEN(32), .NRD(2)) b16 ();

  regfile_sb #(.XLEN(32), .NREGS(32), .NRD(2), .BYPASS(1'b1)) dut32 (
    .clk_i(clk), .reset_i(rst), .rf(b32.slave)
  );
  regfile_sb #(.XLEN(32), .NREGS(16), .NRD(2), .BYPASS(1'b0)) dut16 (
    .clk_i(clk), .reset_i(rst), .rf(b16.slave)
  );

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic [4:0] wi, input logic [31:0] wd,
                       input logic iv, input logic [4:0] ii);
    b32.wen_i = we; b32.rd_idx_i = wi; b32.rd_data_i = wd; b32.iss_valid_i = iv; b32.iss_idx_i = ii;
    b16.wen_i = we; b16.rd_idx_i = wi; b16.rd_data_i = wd; b16.iss_valid_i = iv; b16.iss_idx_i = ii;
  endtask

  task automatic set_clear(input logic c);
    b32.clear_i = c;
    b16.clear_i = c;
  endtask

  task automatic rd(input logic [4:0] a, input logic [4:0] b);
    b32.rs_idx_i = {b, a};
    b16.rs_idx_i = {b, a};
    #1;
  endtask

  function automatic logic [31:0] d32(input int k);
    return b32.rs_data_o[k*32 +: 32];
  endfunction

  function automatic logic [31:0] d16(input int k);
    return b16.rs_data_o[k*32 +: 32];
  endfunction

  // Cycle c counts from 1 after the edge that sampled reset or clear.
  task automatic scrub_watch(input bit noise, input string tag);
    for (int c = 1; c <= 33; c++) begin
      if (noise && c <= 32) drive(1'b1, 5'd3, 32'h0000AAAA, 1'b1, 5'd9);
      else                  drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
      rd(5'd3, 5'd9);
      check({tag, " ready32"}, 32'(b32.ready_o), 32'(c >= 33));
      check({tag, " ready16"}, 32'(b16.ready_o), 32'(c >= 17));
      if (c <= 32) begin
        check({tag, " scrub data32"}, d32(0), 32'h0);
        check({tag, " scrub busy32"}, 32'(b32.rs_busy_o[1]), 32'h0);
      end
      tick();
    end
  endtask

  initial begin
    set_clear(1'b0);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    rd(5'd0, 5'd0);
    tick();
    rst = 1'b0;
    scrub_watch(1'b0, "reset");

    rd(5'd1, 5'd31);
    check("post-reset x1", d32(0), 32'h0);
    check("post-reset x31", d32(1), 32'h0);
    check("post-reset busy", 32'(b32.rs_busy_o), 32'h0);

    // Same-cycle bypass versus registered visibility
    drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0);
    rd(5'd5, 5'd5);
    check("bypass32", d32(0), 32'hDEADBEEF);
    check("bypass32 busy", 32'(b32.rs_busy_o[0]), 32'h0);
    check("nobypass16", d16(0), 32'h0);
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    rd(5'd5, 5'd5);
    check("x5 next32", d32(1), 32'hDEADBEEF);
    check("x5 next16", d16(0), 32'hDEADBEEF);

    // x0 and out-of-range writes
    drive(1'b1, 5'd0, 32'h12345678, 1'b0, 5'd0);
    tick();
    drive(1'b1, 5'd4, 32'h000000AB, 1'b0, 5'd0);
    tick();
    drive(1'b1, 5'd20, 32'h000000FF, 1'b1, 5'd20);
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    rd(5'd0, 5'd0);
    check("x0 p0 32", d32(0), 32'h0);
    check("x0 p1 32", d32(1), 32'h0);
    check("x0 p0 16", d16(0), 32'h0);
    rd(5'd20, 5'd4);
    check("x20 16", d16(0), 32'h0);
    check("x4 16", d16(1), 32'h000000AB);
    check("x20 32", d32(0), 32'h000000FF);
    check("x4 32", d32(1), 32'h000000AB);
    check("x20 busy16", 32'(b16.rs_busy_o[0]), 32'h0);
    check("x20 set-wins32", 32'(b32.rs_busy_o[0]), 32'h1);
    drive(1'b1, 5'd20, 32'h000000FF, 1'b0, 5'd0);
    tick();

    // Scoreboard set / collision / clear
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd7);
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    rd(5'd7, 5'd5);
    check("iss7 busy32", 32'(b32.rs_busy_o[0]), 32'h1);
    check("iss7 busy16", 32'(b16.rs_busy_o[0]), 32'h1);
    check("x5 notbusy32", 32'(b32.rs_busy_o[1]), 32'h0);
    drive(1'b1, 5'd7, 32'h00000077, 1'b1, 5'd7);
    rd(5'd7, 5'd7);
    check("wb7 bypass32", d32(0), 32'h00000077);
    check("wb7 bypass busy32", 32'(b32.rs_busy_o[0]), 32'h0);
    check("wb7 old16", d16(0), 32'h0);
    check("wb7 busy16", 32'(b16.rs_busy_o[0]), 32'h1);
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    rd(5'd7, 5'd7);
    check("collide busy32", 32'(b32.rs_busy_o[1]), 32'h1);
    check("collide busy16", 32'(b16.rs_busy_o[1]), 32'h1);
    check("x7 data32", d32(0), 32'h00000077);
    drive(1'b1, 5'd7, 32'h00000077, 1'b0, 5'd0);
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    rd(5'd7, 5'd7);
    check("wb7 clr busy32", 32'(b32.rs_busy_o[0]), 32'h0);
    check("wb7 clr busy16", 32'(b16.rs_busy_o[0]), 32'h0);
    check("x7 data16", d16(1), 32'h00000077);

    // Fill, then scrub on request
    for (int i = 1; i <= 31; i++) begin
      drive(1'b1, 5'(i), 32'(i) * 32'h11111111, 1'b0, 5'd0);
      tick();
    end
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd9);
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    rd(5'd15, 5'd31);
    check("fill x15 32", d32(0), 32'hFFFFFFFF);
    check("fill x31 32", d32(1), 32'h1111110F);
    check("fill x15 16", d16(0), 32'hFFFFFFFF);
    check("fill x31 16", d16(1), 32'h0);
    rd(5'd9, 5'd9);
    check("iss9 busy32", 32'(b32.rs_busy_o[0]), 32'h1);
    set_clear(1'b1);
    tick();
    set_clear(1'b0);
    scrub_watch(1'b1, "clear");
    for (int i = 1; i <= 31; i++) begin
      rd(5'(i), 5'(i));
      check("scrubbed data32", d32(0), 32'h0);
      check("scrubbed busy32", 32'(b32.rs_busy_o[1]), 32'h0);
    end
    rd(5'd3, 5'd9);
    check("late wr x3 16", d16(0), 32'h0000AAAA);
    check("late iss9 16", 32'(b16.rs_busy_o[1]), 32'h1);

    // Reset in the middle of a scrub restarts it
    set_clear(1'b1);
    tick();
    set_clear(1'b0);
    for (int c = 1; c < 10; c++) tick();
    check("mid-scrub ready32", 32'(b32.ready_o), 32'h0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    scrub_watch(1'b0, "rescrub");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
